// File: rtl/data_pack.sv
// data_pack: repacks a 7-bit value stream (valid/sop/eop) LSB-first into
// 32-bit words, delivered through a DEPTH-entry valid/ready output queue.
// Ports: clk, rst (async active-low), valid_in/data_in/sop_in/eop_in (input
// stream, no stall), valid_out/ready_in/data_out/sop_out/eop_out (word sink),
// overflow (sticky drop flag), protocol_err (pulse on sop inside a packet).
module data_pack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [6:0]  data_in,
    input  logic        sop_in,
    input  logic        eop_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        overflow,
    output logic        protocol_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, PKT} state_t;

    state_t        state_q, state_d;
    logic [38:0]   acc_q, acc_d;
    logic [4:0]    ptr_q, ptr_d;
    logic          first_q, first_d;
    logic          overflow_q, overflow_d;
    logic          perr_q, perr_d;

    logic [33:0]   mem_q [DEPTH];
    logic [33:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start, take;
    logic [38:0]   acc_base, acc_new;
    logic [4:0]    ptr_base;
    logic          first_base;
    logic [5:0]    sum;
    logic [1:0]    n_push;
    logic          w0_sop, w0_eop;
    logic [31:0]   w0_data, w1_data;

    logic          pop, ok0, ok1, drop;
    logic [CW-1:0] free;
    logic [AW-1:0] wr_ptr_p1;
    logic [33:0]   head;

    // Packing: place the value at ptr, emit a word whenever 32 bits fill.
    always_comb begin
        start      = valid_in && sop_in;
        take       = valid_in && (sop_in || state_q == PKT);
        acc_base   = start ? '0 : acc_q;
        ptr_base   = start ? '0 : ptr_q;
        first_base = start ? 1'b1 : first_q;
        acc_new    = acc_base | ({32'd0, data_in} << ptr_base);
        sum        = {1'b0, ptr_base} + 6'd7;

        state_d = state_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        n_push  = 2'd0;
        w0_sop  = first_base;
        w0_eop  = 1'b0;
        w0_data = acc_new[31:0];
        w1_data = {25'd0, acc_new[38:32]};
        perr_d  = start && (state_q == PKT);

        if (take) begin
            state_d = eop_in ? IDLE : PKT;
            if (sum >= 6'd32) begin
                n_push = 2'd1;
                acc_d  = {32'd0, acc_new[38:32]};
                ptr_d  = sum[4:0];
                if (eop_in) begin
                    // Residual bits past the full word need a second push.
                    if (sum > 6'd32) n_push = 2'd2;
                    else             w0_eop = 1'b1;
                    acc_d = '0;
                    ptr_d = '0;
                end
            end else begin
                acc_d = acc_new;
                ptr_d = sum[4:0];
                if (eop_in) begin
                    n_push = 2'd1;
                    w0_eop = 1'b1;
                    acc_d  = '0;
                    ptr_d  = '0;
                end
            end
            first_d = first_base && (n_push == 2'd0);
        end
    end

    // Output queue: a same-cycle pop frees a slot for this cycle's pushes.
    always_comb begin
        pop       = valid_out && ready_in;
        free      = CW'(DEPTH) - cnt_q + CW'(pop);
        ok0       = (n_push != 2'd0) && (free != '0);
        ok1       = (n_push == 2'd2) && (free >= CW'(2));
        drop      = ((n_push != 2'd0) && !ok0) || ((n_push == 2'd2) && !ok1);
        wr_ptr_p1 = wr_ptr_q + AW'(1);

        mem_d = mem_q;
        if (ok0) mem_d[wr_ptr_q]  = {w0_sop, w0_eop, w0_data};
        if (ok1) mem_d[wr_ptr_p1] = {1'b0, 1'b1, w1_data};

        wr_ptr_d   = wr_ptr_q + AW'(ok0) + AW'(ok1);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        cnt_d      = cnt_q - CW'(pop) + CW'(ok0) + CW'(ok1);
        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            overflow_q <= overflow_d;
            perr_q     <= perr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        valid_out    = (cnt_q != '0);
        data_out     = valid_out ? head[31:0] : '0;
        sop_out      = valid_out && head[33];
        eop_out      = valid_out && head[32];
        overflow     = overflow_q;
        protocol_err = perr_q;
    end

endmodule
